// File: rtl/fifo_out2_if.sv
// Byte-in / word-out bus of the output packing FIFO.
// Handshake: a byte moves on a rising clk edge exactly when write_en && in_ready
// are both high at that edge. While write_en is high and in_ready is low, the
// producer holds write_data stable. A pop is requested with read_en. It takes
// effect only when empty is low, and it is answered one cycle later by a
// single-cycle read_valid pulse with read_data.
interface fifo_out2_if #(
  parameter int DATA_WIDTH = 8
);
  logic                      write_en;
  logic [DATA_WIDTH-1:0]     write_data;
  logic                      in_ready;
  logic                      read_en;
  logic [4*DATA_WIDTH-1:0]   read_data;
  logic                      read_valid;
  logic                      full;
  logic                      empty;
  logic                      pad_err;

  modport master (
    output write_en, write_data, read_en,
    input  in_ready, read_data, read_valid, full, empty, pad_err
  );

  modport slave (
    input  write_en, write_data, read_en,
    output in_ready, read_data, read_valid, full, empty, pad_err
  );
endinterface

// File: rtl/fifo_out2.sv
// Output-side packing FIFO. It accepts 7-byte frames of the form
// pad, d0, d1, d2, d3, pad, pad. It strips the pads, packs d0..d3 MSB-first
// into one word, and buffers up to DEPTH words for a word-wide reader.
module fifo_out2 #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  fifo_out2_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int WW = 4 * DATA_WIDTH;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [2:0]      pos_q, pos_d;
  logic [3*W-1:0]  stage_q, stage_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [WW-1:0]   read_data_q, read_data_d;
  logic            read_valid_q, read_valid_d;
  logic            pad_err_q, pad_err_d;
  logic [WW-1:0]   mem_q [DEPTH];

  logic full_w, empty_w, in_ready_w, acc, push, pop, pad_pos;

  // Status flags, the accept/push/pop strobes, and the next-state values.
  // Only the byte at position 4 can stall, because it is the only byte that
  // needs a free word slot.
  always_comb begin
    full_w       = (count_q == CW'(DEPTH));
    empty_w      = (count_q == '0);
    in_ready_w   = !((pos_q == 3'd4) && full_w);
    acc          = bus.write_en && in_ready_w;
    push         = acc && (pos_q == 3'd4);
    pop          = bus.read_en && !empty_w;
    pad_pos      = (pos_q == 3'd0) || (pos_q == 3'd5) || (pos_q == 3'd6);

    pos_d        = pos_q;
    stage_d      = stage_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    pad_err_d    = pad_err_q;

    if (acc) begin
      pos_d = (pos_q == 3'd6) ? 3'd0 : pos_q + 3'd1;
      case (pos_q)
        3'd1:    stage_d[3*W-1:2*W] = bus.write_data;
        3'd2:    stage_d[2*W-1:W]   = bus.write_data;
        3'd3:    stage_d[W-1:0]     = bus.write_data;
        default: ;
      endcase
      if (pad_pos && (bus.write_data != '0)) pad_err_d = 1'b1;
    end

    if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);

    if (pop) begin
      read_data_d  = mem_q[rd_ptr_q];
      read_valid_d = 1'b1;
      rd_ptr_d     = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase
  end

  // Control and output registers. Reset drops any partially staged word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pos_q        <= '0;
      stage_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      pad_err_q    <= 1'b0;
    end else begin
      pos_q        <= pos_d;
      stage_q      <= stage_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      pad_err_q    <= pad_err_d;
    end
  end

  // Word storage. It is not reset. A same-cycle pop reads the old contents.
  always_ff @(posedge clk) begin
    if (rst && push) mem_q[wr_ptr_q] <= {stage_q, bus.write_data};
  end

  assign bus.in_ready   = in_ready_w;
  assign bus.full       = full_w;
  assign bus.empty      = empty_w;
  assign bus.read_data  = read_data_q;
  assign bus.read_valid = read_valid_q;
  assign bus.pad_err    = pad_err_q;
endmodule
